// File: rtl/mm_mem_responder.sv
// Memory-side responder for the matrix-multiply controller: serves header/A/B reads
// with zero latency, captures results into C in row-major order, and sequences host runs.
module mm_mem_responder #(
  parameter int MAX_DIM = 4,
  parameter int DW      = 20,
  parameter int RW      = 40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [1:0]    load_sel,
  input  logic [7:0]    load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          start,
  input  logic          clear,
  output logic          mm_rst,
  input  logic [19:0]   i,
  input  logic [19:0]   j,
  input  logic          read,
  input  logic          write,
  input  logic          index,
  input  logic [RW-1:0] write_data,
  input  logic          finish,
  output logic [DW-1:0] read_data,
  input  logic [7:0]    rd_addr,
  output logic [RW-1:0] rd_data,
  output logic [7:0]    wr_count,
  output logic          done,
  output logic          err_oob,
  output logic          err_ovf,
  output logic          err_short
);

  localparam int NCELL = MAX_DIM * MAX_DIM;
  localparam int AW    = $clog2(NCELL);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;
  state_t state, next_state;

  logic [DW-1:0] m1_row, m1_column, m2_column;
  logic [DW-1:0] mem_a [NCELL];
  logic [DW-1:0] mem_b [NCELL];
  logic [RW-1:0] mem_c [NCELL];

  logic          in_run, in_load;
  logic          hdr_rd, mat_rd, res_wr;
  logic          ij_small, a_ok, b_ok;
  logic [7:0]    a_addr, b_addr, capacity;
  logic          acc_oob, store_ok, store_ovf;
  logic [7:0]    wr_count_nxt;
  logic [DW-1:0] hdr_clamped;
  logic          enter_run;

  assign in_run  = (state == S_RUN);
  assign in_load = (state == S_LOAD);
  assign done    = (state == S_DONE);

  assign hdr_rd = in_run & read & write & ~index;
  assign mat_rd = in_run & read & ~write;
  assign res_wr = in_run & write & ~read;

  // Full-width index compares make any i/j >= MAX_DIM out of range even when the
  // low bits used for addressing would alias into the array.
  assign ij_small = (i < 20'(MAX_DIM)) && (j < 20'(MAX_DIM));
  assign a_addr   = i[7:0] * m1_column[7:0] + j[7:0];
  assign b_addr   = i[7:0] * m2_column[7:0] + j[7:0];
  assign a_ok     = ij_small && (i < m1_row) && (j < m1_column) && (a_addr < 8'(NCELL));
  assign b_ok     = ij_small && (i < m1_column) && (j < m2_column) && (b_addr < 8'(NCELL));
  assign capacity = m1_row[7:0] * m2_column[7:0];

  always_comb begin
    read_data = '0;
    acc_oob   = 1'b0;
    if (hdr_rd) begin
      if (i == 20'd0)      read_data = m1_row;
      else if (i == 20'd1) read_data = m1_column;
      else if (i == 20'd2) read_data = m2_column;
      else                 acc_oob   = 1'b1;
    end else if (mat_rd) begin
      if (!index) begin
        if (a_ok) read_data = mem_a[a_addr[AW-1:0]];
        else      acc_oob   = 1'b1;
      end else begin
        if (b_ok) read_data = mem_b[b_addr[AW-1:0]];
        else      acc_oob   = 1'b1;
      end
    end
  end

  assign store_ok     = res_wr && (wr_count < capacity);
  assign store_ovf    = res_wr && !store_ok;
  assign wr_count_nxt = wr_count + 8'(store_ok);

  assign hdr_clamped = (load_data > DW'(MAX_DIM)) ? DW'(MAX_DIM) : load_data;

  always_comb begin
    next_state = state;
    case (state)
      S_LOAD:  if (start) next_state = S_RUN;
      S_RUN:   if (finish) next_state = S_DONE;
      S_DONE: begin
        if (start)      next_state = S_RUN;
        else if (clear) next_state = S_LOAD;
      end
      default: next_state = S_LOAD;
    endcase
  end

  assign enter_run = (next_state == S_RUN) && !in_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_LOAD;
      mm_rst    <= 1'b1;
      wr_count  <= '0;
      err_oob   <= 1'b0;
      err_ovf   <= 1'b0;
      err_short <= 1'b0;
      m1_row    <= '0;
      m1_column <= '0;
      m2_column <= '0;
    end else begin
      state  <= next_state;
      mm_rst <= (next_state != S_RUN);
      if (enter_run) begin
        wr_count  <= '0;
        err_oob   <= 1'b0;
        err_ovf   <= 1'b0;
        err_short <= 1'b0;
      end else if (in_run) begin
        wr_count <= wr_count_nxt;
        if (acc_oob)   err_oob <= 1'b1;
        if (store_ovf) err_ovf <= 1'b1;
        if (finish && (wr_count_nxt != capacity)) err_short <= 1'b1;
      end
      if (in_load && load_en && (load_sel == 2'd0)) begin
        case (load_addr)
          8'd0:    m1_row    <= hdr_clamped;
          8'd1:    m1_column <= hdr_clamped;
          8'd2:    m2_column <= hdr_clamped;
          default: ;
        endcase
      end
    end
  end

  // Operand and result storage carry no reset; the host reloads before every run.
  always_ff @(posedge clk) begin
    if (in_load && load_en && (load_addr < 8'(NCELL))) begin
      if (load_sel == 2'd1) mem_a[load_addr[AW-1:0]] <= load_data;
      if (load_sel == 2'd2) mem_b[load_addr[AW-1:0]] <= load_data;
    end
    if (store_ok) mem_c[wr_count[AW-1:0]] <= write_data;
  end

  assign rd_data = (rd_addr < 8'(NCELL)) ? mem_c[rd_addr[AW-1:0]] : '0;

endmodule

// File: tb/tb_mm_mem_responder.sv
// Directed plus randomized bench for mm_mem_responder; the bench plays both host and
// controller and predicts every response from a matrix-level reference model.
module tb_mm_mem_responder;

  localparam int MAX_DIM = 4;
  localparam int DW      = 20;
  localparam int RW      = 40;
  localparam int NCELL   = MAX_DIM * MAX_DIM;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_en;
  logic [1:0]    load_sel;
  logic [7:0]    load_addr;
  logic [DW-1:0] load_data;
  logic          start, clear;
  logic          mm_rst;
  logic [19:0]   i, j;
  logic          read, write, index;
  logic [RW-1:0] write_data;
  logic          finish;
  logic [DW-1:0] read_data;
  logic [7:0]    rd_addr;
  logic [RW-1:0] rd_data;
  logic [7:0]    wr_count;
  logic          done, err_oob, err_ovf, err_short;

  mm_mem_responder #(.MAX_DIM(MAX_DIM), .DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .start(start), .clear(clear),
    .mm_rst(mm_rst), .i(i), .j(j), .read(read), .write(write), .index(index),
    .write_data(write_data), .finish(finish), .read_data(read_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count), .done(done),
    .err_oob(err_oob), .err_ovf(err_ovf), .err_short(err_short)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0] ma [NCELL];
  logic [DW-1:0] mb [NCELL];
  logic [RW-1:0] ec [NCELL];
  int unsigned   hr, hc, hbc;
  bit            exp_oob;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned clamp(input int unsigned v);
    return (v > MAX_DIM) ? MAX_DIM : v;
  endfunction

  // Expected controller response from the decode rules, at matrix level
  function automatic void model_read(input bit rd, input bit wr, input bit idx,
                                     input int unsigned ii, input int unsigned jj,
                                     output logic [DW-1:0] d, output bit oob);
    d = '0;
    oob = 1'b0;
    if (rd && wr && !idx) begin
      if (ii == 0)      d = DW'(hr);
      else if (ii == 1) d = DW'(hc);
      else if (ii == 2) d = DW'(hbc);
      else              oob = 1'b1;
    end else if (rd && !wr) begin
      if (!idx) begin
        if (ii < hr && jj < hc) d = ma[ii*hc + jj];
        else                    oob = 1'b1;
      end else begin
        if (ii < hc && jj < hbc) d = mb[ii*hbc + jj];
        else                     oob = 1'b1;
      end
    end
  endfunction

  task automatic idle_ctrl;
    read = 0; write = 0; index = 0; i = '0; j = '0; write_data = '0; finish = 0;
  endtask

  task automatic host_load(input logic [1:0] sel, input logic [7:0] addr, input logic [DW-1:0] data);
    load_en = 1; load_sel = sel; load_addr = addr; load_data = data;
    tick;
    load_en = 0;
  endtask

  task automatic load_all(input int unsigned r, input int unsigned c, input int unsigned bc);
    host_load(2'd0, 8'd0, DW'(r));
    host_load(2'd0, 8'd1, DW'(c));
    host_load(2'd0, 8'd2, DW'(bc));
    hr = clamp(r); hc = clamp(c); hbc = clamp(bc);
    for (int n = 0; n < NCELL; n++) begin
      host_load(2'd1, 8'(n), ma[n]);
      host_load(2'd2, 8'(n), mb[n]);
    end
  endtask

  task automatic do_start;
    start = 1;
    tick;
    start = 0;
    chk("start_mm_rst", mm_rst, 0);
    chk("start_done", done, 0);
    chk("start_wr_count", wr_count, 0);
    chk("start_errs", {err_oob, err_ovf, err_short}, 0);
    exp_oob = 0;
  endtask

  task automatic ctrl_req(input string tag, input bit rd, input bit wr, input bit idx,
                          input int unsigned ii, input int unsigned jj);
    logic [DW-1:0] d;
    bit oob;
    model_read(rd, wr, idx, ii, jj, d, oob);
    exp_oob |= oob;
    read = rd; write = wr; index = idx; i = 20'(ii); j = 20'(jj);
    #1 chk(tag, read_data, d);
    tick;
    idle_ctrl;
  endtask

  task automatic ctrl_write(input logic [RW-1:0] v);
    write = 1; read = 0; write_data = v;
    tick;
    idle_ctrl;
  endtask

  task automatic hdr_check;
    for (int unsigned n = 0; n < 3; n++) ctrl_req("hdr_rd", 1, 1, 0, n, 0);
  endtask

  // Controller behaviour: full matrix product, checking every operand fetched
  task automatic run_mm;
    logic signed [RW-1:0] acc;
    int unsigned n;
    n = 0;
    for (int unsigned r = 0; r < hr; r++) begin
      for (int unsigned c = 0; c < hbc; c++) begin
        acc = '0;
        for (int unsigned k = 0; k < hc; k++) begin
          ctrl_req("rd_a", 1, 0, 0, r, k);
          ctrl_req("rd_b", 1, 0, 1, k, c);
          acc = acc + $signed(ma[r*hc + k]) * $signed(mb[k*hbc + c]);
        end
        ec[n] = acc;
        ctrl_write(acc);
        n++;
      end
    end
  endtask

  task automatic finish_run(input logic [7:0] exp_wr, input bit exp_short);
    finish = 1;
    tick;
    finish = 0;
    chk("fin_done", done, 1);
    chk("fin_mm_rst", mm_rst, 1);
    chk("fin_wr_count", wr_count, exp_wr);
    chk("fin_err_short", err_short, exp_short);
  endtask

  task automatic check_c(input int unsigned cnt);
    for (int unsigned n = 0; n < cnt; n++) begin
      rd_addr = 8'(n);
      #1 chk("c_readback", rd_data, ec[n]);
    end
  endtask

  task automatic do_clear;
    clear = 1;
    tick;
    clear = 0;
    chk("clear_done", done, 0);
    chk("clear_mm_rst", mm_rst, 1);
  endtask

  initial begin
    reset = 1; load_en = 0; load_sel = '0; load_addr = '0; load_data = '0;
    start = 0; clear = 0; rd_addr = '0;
    idle_ctrl;
    hr = 0; hc = 0; hbc = 0; exp_oob = 0;
    #12;
    chk("rst_mm_rst", mm_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_errs", {err_oob, err_ovf, err_short}, 0);
    tick;
    reset = 0;
    tick;

    // Requests in LOAD are ignored
    read = 1; index = 0;
    #1 chk("load_read_data", read_data, 0);
    idle_ctrl;

    // 2x2 product with dropped out-of-range and invalid-select loads
    for (int n = 0; n < NCELL; n++) begin ma[n] = '0; mb[n] = '0; end
    ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
    mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
    load_all(2, 2, 2);
    host_load(2'd1, 8'd16, 20'd99);
    host_load(2'd3, 8'd0, 20'd55);
    do_start;
    hdr_check;
    run_mm;
    finish_run(8'd4, 0);
    chk("t1_errs", {err_oob, err_ovf}, 0);
    check_c(4);
    rd_addr = 8'd0; #1 chk("t1_c0", rd_data, 40'd19);
    rd_addr = 8'd1; #1 chk("t1_c1", rd_data, 40'd22);
    rd_addr = 8'd2; #1 chk("t1_c2", rd_data, 40'd43);
    rd_addr = 8'd3; #1 chk("t1_c3", rd_data, 40'd50);
    rd_addr = 8'd16; #1 chk("rd_oob_zero", rd_data, 0);

    // Loads in DONE ignored; out-of-range read sticky; DONE -> RUN via start
    host_load(2'd1, 8'd0, 20'd77);
    do_start;
    ctrl_req("a0_kept", 1, 0, 0, 0, 0);
    ctrl_req("oob_rd", 1, 0, 0, 2, 0);
    chk("oob_set", err_oob, 1);
    tick;
    chk("oob_sticky", err_oob, 1);
    finish_run(8'd0, 1);
    rd_addr = 8'd0; #1 chk("c_frozen", rd_data, 40'd19);
    do_clear;

    // Signed operands
    for (int n = 0; n < NCELL; n++) begin ma[n] = '0; mb[n] = '0; end
    ma[0] = 20'hFFFFD; mb[0] = 20'd4;
    load_all(1, 1, 1);
    do_start;
    run_mm;
    finish_run(8'd1, 0);
    rd_addr = 8'd0; #1 chk("signed_c0", rd_data, 40'hFFFFFFFFF4);
    do_clear;

    // Overflow: second write beyond capacity is dropped
    do_start;
    ctrl_write(40'd7);
    ctrl_write(40'd9);
    rd_addr = 8'd0; #1 chk("ovf_c0", rd_data, 40'd7);
    chk("ovf_wr_count", wr_count, 1);
    chk("ovf_flag", err_ovf, 1);
    finish_run(8'd1, 0);
    do_clear;

    // Short run, then start and clear together
    host_load(2'd0, 8'd0, 20'd2);
    host_load(2'd0, 8'd1, 20'd2);
    host_load(2'd0, 8'd2, 20'd2);
    do_start;
    ctrl_write(40'd1);
    ctrl_write(40'd2);
    finish_run(8'd2, 1);
    start = 1; clear = 1;
    tick;
    start = 0; clear = 0;
    chk("sc_mm_rst", mm_rst, 0);
    chk("sc_done", done, 0);
    chk("sc_wr_count", wr_count, 0);
    chk("sc_errs", {err_oob, err_ovf, err_short}, 0);

    // Asynchronous reset mid-RUN
    ctrl_write(40'd3);
    chk("mid_wr_count", wr_count, 1);
    #2 reset = 1;
    #1;
    chk("arst_mm_rst", mm_rst, 1);
    chk("arst_done", done, 0);
    chk("arst_wr_count", wr_count, 0);
    tick;
    reset = 0;
    tick;

    // Randomized runs: headers include 0 and values needing clamping
    for (int it = 0; it < 8; it++) begin
      int unsigned r, c, bc;
      r = $urandom_range(0, 5); c = $urandom_range(0, 5); bc = $urandom_range(0, 5);
      for (int n = 0; n < NCELL; n++) begin ma[n] = DW'($urandom); mb[n] = DW'($urandom); end
      load_all(r, c, bc);
      do_start;
      hdr_check;
      run_mm;
      for (int p = 0; p < 10; p++) begin
        bit rd, wr, idx;
        int unsigned ii, jj;
        rd = 1'($urandom); wr = rd ? 1'($urandom) : 1'b0; idx = 1'($urandom);
        ii = $urandom_range(0, 6); jj = $urandom_range(0, 6);
        if (ii == 6) ii = 256;
        if (jj == 6) jj = 256;
        ctrl_req("probe", rd, wr, idx, ii, jj);
      end
      finish_run(8'(hr * hbc), 0);
      chk("rand_oob", err_oob, exp_oob);
      chk("rand_ovf", err_ovf, 0);
      check_c(hr * hbc);
      do_clear;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
